// File: rtl/proc_iu_core.sv
// Minimal multi-cycle SPARC V8 subset integer unit: SETHI/NOP, ADD/AND/OR/XOR/SUB, LD, ST.
// Optional register debug read port enabled by defining PROC_DBG_EN.
module proc_iu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pciclk,
    input  logic        iui_hold,
    output logic        iuo_retire,
    output logic [31:0] iuo_pc,
    output logic        iuo_err,
    output logic        ici_req,
    output logic [31:0] ici_addr,
    input  logic        ico_valid,
    input  logic [31:0] ico_data,
    output logic        dci_rd,
    output logic        dci_wr,
    output logic [31:0] dci_addr,
    output logic [31:0] dci_wdata,
    input  logic        dco_valid,
    input  logic [31:0] dco_data
`ifdef PROC_DBG_EN
    ,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
`endif
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;
    localparam logic [1:0] WB    = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc, ir, result;
    logic        wen, err_q;
    logic [31:0] regs [NREGS];

    logic        unused_pciclk;
    assign unused_pciclk = pciclk;

    logic [1:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [5:0]  op3;
    logic [31:0] rs1_val, rs2_val, rd_val, op2_val, sum;
    logic        is_sethi, is_alu, is_ld, is_st;
    logic [31:0] alu_res;

    assign op      = ir[31:30];
    assign rd      = ir[29:25];
    assign op3     = ir[24:19];
    assign rs1     = ir[18:14];
    assign rs2     = ir[4:0];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign rd_val  = (rd == 5'd0) ? 32'd0 : regs[rd];
    assign op2_val = ir[13] ? {{19{ir[12]}}, ir[12:0]} : rs2_val;
    assign sum     = rs1_val + op2_val;
    assign ici_addr = pc;

    always_comb begin
        is_sethi = (op == 2'b00) && (ir[24:22] == 3'b100);
        is_alu   = (op == 2'b10) && (op3 <= 6'h04);
        is_ld    = (op == 2'b11) && (op3 == 6'h00);
        is_st    = (op == 2'b11) && (op3 == 6'h04);
        alu_res  = {ir[21:0], 10'd0};
        if (is_alu) begin
            case (op3)
                6'h00:   alu_res = sum;
                6'h01:   alu_res = rs1_val & op2_val;
                6'h02:   alu_res = rs1_val | op2_val;
                6'h03:   alu_res = rs1_val ^ op2_val;
                default: alu_res = rs1_val - op2_val;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            result     <= '0;
            wen        <= 1'b0;
            err_q      <= 1'b0;
            ici_req    <= 1'b0;
            dci_rd     <= 1'b0;
            dci_wr     <= 1'b0;
            dci_addr   <= '0;
            dci_wdata  <= '0;
            iuo_retire <= 1'b0;
            iuo_err    <= 1'b0;
            iuo_pc     <= '0;
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            iuo_retire <= 1'b0;
            iuo_err    <= 1'b0;
            case (state)
                FETCH: begin
                    // Once raised, the request stays up until the icache answers.
                    if (!ici_req) begin
                        ici_req <= !iui_hold;
                    end else if (ico_valid) begin
                        ici_req <= 1'b0;
                        ir      <= ico_data;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    wen    <= is_sethi | is_alu | is_ld;
                    err_q  <= !(is_sethi | is_alu | is_ld | is_st);
                    result <= alu_res;
                    if (is_ld || is_st) begin
                        dci_rd    <= is_ld;
                        dci_wr    <= is_st;
                        dci_addr  <= {sum[31:2], 2'b00};
                        dci_wdata <= rd_val;
                        state     <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (dco_valid) begin
                        dci_rd <= 1'b0;
                        dci_wr <= 1'b0;
                        if (dci_rd) result <= dco_data;
                        state <= WB;
                    end
                end
                default: begin
                    if (wen && rd != 5'd0) regs[rd] <= result;
                    iuo_retire <= 1'b1;
                    iuo_err    <= err_q;
                    iuo_pc     <= pc;
                    pc         <= pc + 32'd4;
                    // Issue the next fetch straight away to keep the 3-cycle minimum.
                    ici_req    <= !iui_hold;
                    state      <= FETCH;
                end
            endcase
        end
    end

`ifdef PROC_DBG_EN
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];
`endif
endmodule

// File: tb/tb_proc_iu_core.sv
// Directed bench for proc_iu_core: drives icache/dcache responses, scoreboards retires and data accesses.
module tb_proc_iu_core;
    logic        clk = 0, rst = 1, pciclk = 0, iui_hold = 0;
    logic        iuo_retire, iuo_err, ici_req, dci_rd, dci_wr;
    logic [31:0] iuo_pc, ici_addr, dci_addr, dci_wdata;
    logic        ico_valid = 0, dco_valid = 0;
    logic [31:0] ico_data = 0, dco_data = 0;

    int nvec = 0, nmis = 0;
    logic [31:0] mpc;

    typedef struct { logic [31:0] pc; logic err; } ret_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wd; int hold; } mem_t;
    ret_t rq[$];
    mem_t mq[$];

    always #5 clk = ~clk;
    always #7 pciclk = ~pciclk;

    proc_iu_core dut (
        .clk(clk), .rst(rst), .pciclk(pciclk), .iui_hold(iui_hold),
        .iuo_retire(iuo_retire), .iuo_pc(iuo_pc), .iuo_err(iuo_err),
        .ici_req(ici_req), .ici_addr(ici_addr), .ico_valid(ico_valid), .ico_data(ico_data),
        .dci_rd(dci_rd), .dci_wr(dci_wr), .dci_addr(dci_addr), .dci_wdata(dci_wdata),
        .dco_valid(dco_valid), .dco_data(dco_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sethi(input logic [4:0] r, input logic [21:0] imm);
        return {2'b00, r, 3'b100, imm};
    endfunction
    function automatic logic [31:0] f3i(input logic [1:0] op, input logic [4:0] r,
                                        input logic [5:0] op3, input logic [4:0] rs1,
                                        input logic [12:0] simm);
        return {op, r, op3, rs1, 1'b1, simm};
    endfunction
    function automatic logic [31:0] f3r(input logic [1:0] op, input logic [4:0] r,
                                        input logic [5:0] op3, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {op, r, op3, rs1, 1'b0, 8'd0, rs2};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // mk: 0 none, 1 load, 2 store. abort leaves the data access unanswered.
    task automatic xi(input logic [31:0] ins, input int iw, input logic err, input int mk,
                      input logic [31:0] maddr, input logic [31:0] mwd, input int dw,
                      input logic [31:0] ldat, input bit abort);
        int n = 0;
        while (!ici_req && n < 50) begin step(); n++; end
        if (!ici_req) begin chk("fetch_timeout", 0, 1); return; end
        chk("ici_addr", ici_addr, mpc);
        for (int k = 0; k < iw; k++) begin
            step();
            chk("ici_req_held", {31'd0, ici_req}, 1);
            chk("ici_addr_held", ici_addr, mpc);
        end
        ico_valid = 1; ico_data = ins;
        if (!abort) rq.push_back('{pc: mpc, err: err});
        if (mk != 0) mq.push_back('{wr: (mk == 2), addr: maddr, wd: mwd, hold: abort ? 0 : dw + 1});
        step();
        ico_valid = 0; ico_data = 32'hDEAD_BEEF;
        if (mk != 0) begin
            n = 0;
            while (!(dci_rd || dci_wr) && n < 50) begin step(); n++; end
            if (!(dci_rd || dci_wr)) begin chk("dcache_timeout", 0, 1); return; end
            if (abort) begin step(); step(); return; end
            repeat (dw) step();
            dco_valid = 1; dco_data = ldat;
            step();
            dco_valid = 0; dco_data = 32'hBAD0_BAD0;
        end
        mpc = mpc + 32'd4;
    endtask

    task automatic x(input logic [31:0] ins);
        xi(ins, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic st(input logic [4:0] r, input logic [12:0] off, input logic [31:0] ea,
                      input logic [31:0] wd);
        xi(f3i(2'b11, r, 6'h04, 5'd0, off), 0, 0, 2, ea, wd, 1, 0, 0);
    endtask

    // Scoreboard side: retires and data-cache accesses are checked as they appear.
    int hold_cnt = 0, exp_hold = 0;
    bit mact = 0;
    logic [31:0] snap_addr, snap_wd;
    always @(negedge clk) begin
        ret_t r;
        mem_t m;
        if (rst) begin
            mact = 0;
        end else begin
            if (iuo_retire) begin
                if (rq.size() == 0) chk("retire_spurious", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("iuo_pc", iuo_pc, r.pc);
                    chk("iuo_err", {31'd0, iuo_err}, {31'd0, r.err});
                end
            end else if (iuo_err) chk("err_without_retire", 1, 0);
            if ((dci_rd || dci_wr) && !mact) begin
                if (mq.size() == 0) chk("dcache_spurious", 1, 0);
                else begin
                    m = mq.pop_front();
                    chk("dci_rd", {31'd0, dci_rd}, {31'd0, !m.wr});
                    chk("dci_wr", {31'd0, dci_wr}, {31'd0, m.wr});
                    chk("dci_addr", dci_addr, m.addr);
                    if (m.wr) chk("dci_wdata", dci_wdata, m.wd);
                    exp_hold = m.hold;
                end
                hold_cnt = 1; snap_addr = dci_addr; snap_wd = dci_wdata;
            end else if (dci_rd || dci_wr) begin
                hold_cnt++;
                chk("dci_addr_stable", dci_addr, snap_addr);
                chk("dci_wdata_stable", dci_wdata, snap_wd);
            end
            if (!(dci_rd || dci_wr) && mact && exp_hold != 0)
                chk("dci_hold_cycles", hold_cnt, exp_hold);
            mact = dci_rd || dci_wr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mpc = 32'h0;
        repeat (3) step();
        chk("rst_ici_req", {31'd0, ici_req}, 0);
        chk("rst_ici_addr", ici_addr, 0);
        chk("rst_dci_rd", {31'd0, dci_rd}, 0);
        chk("rst_dci_wr", {31'd0, dci_wr}, 0);
        chk("rst_dci_addr", dci_addr, 0);
        chk("rst_dci_wdata", dci_wdata, 0);
        chk("rst_iuo_retire", {31'd0, iuo_retire}, 0);
        chk("rst_iuo_pc", iuo_pc, 0);
        chk("rst_iuo_err", {31'd0, iuo_err}, 0);
        rst = 0;

        // NOPs at 0,4,8; one stalls the icache to test request hold.
        x(32'h0100_0000);
        xi(32'h0100_0000, 2, 0, 0, 0, 0, 0, 0, 0);
        x(32'h0100_0000);
        st(5'd7, 13'h0, 32'h0, 32'h0);

        // ri = i*i via SETHI/OR, then write to r0 must be discarded.
        for (int i = 1; i < 32; i++) begin
            x(sethi(5'(i), 22'((i * i) >> 10)));
            x(f3i(2'b10, 5'(i), 6'h02, 5'(i), 13'((i * i) & 32'h3ff)));
        end
        x(sethi(5'd0, 22'h3ff));
        for (int i = 1; i < 32; i++) st(5'(i), 13'(4 * i), 32'(4 * i), 32'(i * i));
        st(5'd0, 13'h0, 32'h0, 32'h0);

        // ALU ops: wrap-around, negative immediates, register operand.
        x(sethi(5'd1, 22'h3fffff));
        x(f3i(2'b10, 5'd2, 6'h00, 5'd1, 13'h400));
        x(f3i(2'b10, 5'd3, 6'h03, 5'd1, 13'h1fff));
        x(f3r(2'b10, 5'd4, 6'h01, 5'd3, 5'd9));
        x(f3i(2'b10, 5'd6, 6'h04, 5'd0, 13'h1));
        x(f3r(2'b10, 5'd10, 6'h00, 5'd31, 5'd30));
        st(5'd1, 13'h0, 32'h0, 32'hFFFF_FC00);
        st(5'd2, 13'h4, 32'h4, 32'h0);
        st(5'd3, 13'h8, 32'h8, 32'h0000_03FF);
        st(5'd4, 13'hc, 32'hc, 32'h0000_0051);
        st(5'd6, 13'h10, 32'h10, 32'hFFFF_FFFF);
        st(5'd10, 13'h14, 32'h14, 32'h0000_0745);

        // LD with 3 wait cycles, then ST of the loaded value to an unaligned offset.
        xi(f3i(2'b11, 5'd5, 6'h00, 5'd0, 13'h100), 0, 0, 1, 32'h100, 0, 3, 32'h100, 0);
        xi(f3i(2'b11, 5'd5, 6'h04, 5'd0, 13'h23), 0, 0, 2, 32'h20, 32'h100, 2, 0, 0);

        // Unsupported CALL retires with an error pulse; PC still advances.
        xi(32'h4000_0000, 0, 1, 0, 0, 0, 0, 0, 0);

        // Hold: no request while set, stray ico_valid ignored, fetch resumes after.
        iui_hold = 1;
        repeat (3) step();
        ico_valid = 1; ico_data = sethi(5'd5, 22'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_no_req", {31'd0, ici_req}, 0);
        end
        ico_valid = 0;
        iui_hold = 0;
        x(32'h0100_0000);
        st(5'd5, 13'h0, 32'h0, 32'h100);

        // Reset in the middle of a load wait.
        xi(f3i(2'b11, 5'd8, 6'h00, 5'd0, 13'h40), 0, 0, 1, 32'h40, 0, 0, 0, 1);
        rst = 1;
        step();
        chk("mrst_dci_rd", {31'd0, dci_rd}, 0);
        chk("mrst_ici_addr", ici_addr, 32'h0);
        chk("mrst_ici_req", {31'd0, ici_req}, 0);
        rst = 0;
        mpc = 32'h0;
        x(32'h0100_0000);
        st(5'd5, 13'h0, 32'h0, 32'h0);

        repeat (10) step();
        chk("retire_queue_empty", rq.size(), 0);
        chk("mem_queue_empty", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/proc_iu_core.md
Name: proc_iu_core

Overview:
- Minimal multi-cycle integer unit (SPARC V8 subset) sitting between separate instruction-cache and data-cache interfaces.
- Fetches 32-bit instructions over the icache port and executes SETHI/NOP, ALU ops, LD and ST. Memory operations go over the dcache port.
- Exposes retire/error status to the system through the iuo outputs.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NREGS, 32, register count (r0 reads as zero, writes to r0 discarded)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
pciclk  in  1  legacy pin, kept for pin compatibility; ignored internally
iui_hold  in  1  when 1, core stays in FETCH and issues no new request
iuo_retire  out  1  one-cycle pulse when an instruction completes
iuo_pc  out  32  address of the last retired instruction
iuo_err  out  1  one-cycle pulse on retiring an unsupported instruction
ici_req  out  1  instruction fetch request
ici_addr  out  32  fetch address, word aligned
ico_valid  in  1  fetch data valid
ico_data  in  32  fetched instruction
dci_rd  out  1  data read request
dci_wr  out  1  data write request
dci_addr  out  32  data address
dci_wdata  out  32  store data
dco_valid  in  1  data access complete
dco_data  in  32  load data

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - PC=RESET_PC; state=FETCH; all registers cleared to 0.
  - All outputs 0: iuo_pc=0, ici_addr=0, dci_*=0.
  - Reset asserted mid-access abandons the access; the request lines drop the next cycle.
- States: FETCH, EXEC, MEM, WB.
- FETCH:
  - Entered only with iui_hold=0; otherwise it waits with ici_req=0.
  - Drives ici_req=1 and ici_addr=PC. Both are held stable until a cycle with ico_valid=1.
  - On that cycle, latch ico_data into IR and go to EXEC.
  - ico_valid while ici_req=0 is ignored.
- EXEC decodes IR (SPARC V8 fields: op[31:30], rd[29:25], op3[24:19], rs1[18:14], i[13], simm13[12:0], rs2[4:0]):
  - op=00, op2=100 SETHI: rd <= imm22<<10. 0x01000000 (sethi 0,%g0) is the NOP.
  - op=10 ALU, operand2 = i ? sign-extended simm13 : R[rs2]:
    - op3 0x00 ADD, 0x01 AND, 0x02 OR, 0x03 XOR, 0x04 SUB.
    - 32-bit wrap-around; no condition codes.
  - op=11 memory, address = R[rs1]+operand2, go to MEM:
    - op3 0x00 LD.
    - op3 0x04 ST, with dci_wdata=R[rd].
    - Address bits [1:0] forced to 00.
  - Anything else is unsupported: executes as NOP and pulses iuo_err at retire.
  - Non-memory instructions go to WB.
- MEM:
  - dci_rd or dci_wr (never both) held with dci_addr/dci_wdata until dco_valid=1.
  - LD latches dco_data; then go to WB.
- WB:
  - Writes the result to rd (suppressed for rd=0 and for ST).
  - Pulses iuo_retire; sets iuo_pc=PC; PC<=PC+4 (wraps at 2^32); go to FETCH.
- Latency: minimum 3 cycles per non-memory instruction and 4 per memory instruction, plus cache wait cycles.
- Register read-after-write: the result is visible to the next instruction, since execution is strictly sequential.

Optional Feature:
PROC_DBG_EN
- Defined: adds ports dbg_raddr (in, 5) and dbg_rdata (out, 32).
  - dbg_rdata is a combinational read of R[dbg_raddr]; it reads 0 for r0.
  - The debug read does not disturb execution.
- Undefined: no debug ports and no additional logic.

Test Plan:
- Reset, then icache returns 0x01000000 every fetch with 1-cycle latency -> ici_addr sequence 0,4,8; one iuo_retire per NOP; iuo_err=0; all registers remain 0.
- For i=1..31: SETHI %hi(i*i) into ri, then OR ri,%lo(i*i),ri (e.g. i=31 -> r31=0x3C1) -> each ri reads i*i; write to r0 leaves r0=0.
- LD r5,[r0+0x100] with dco_data=0x100 after 3 wait cycles -> dci_rd held for 4 cycles at dci_addr=0x100; r5=0x100; one retire.
- ST r5,[r0+0x20] -> dci_wr=1, dci_addr=0x20, dci_wdata=0x100 held until dco_valid; no register change.
- Instruction 0x40000000 (CALL, unsupported) -> iuo_err pulse with iuo_retire; PC advances by 4.
- rst asserted during MEM wait, and separately iui_hold=1 -> after rst, next cycle has dci_rd=0 and ici_addr=RESET_PC; while hold is set, ici_req stays 0 and fetch resumes when hold drops.
